// File: rtl/lvds_tx_pkg.sv
// Shared definitions for the LVDS transmit path.
//   lock_state_e  : PLL lock supervisor states
//   Default*      : default cycle parameters for the lock supervisor
//   max3()        : elaboration-time helper for sizing shared counters
package lvds_tx_pkg;

    typedef enum logic [2:0] {
        StRst,
        StWait,
        StStable,
        StRun,
        StFault
    } lock_state_e;

    localparam int unsigned DefaultRstHoldCyc     = 16;
    localparam int unsigned DefaultLockTimeoutCyc = 167000;  // 2 ms at 83.5 MHz
    localparam int unsigned DefaultLockStableCyc  = 1024;
    localparam int unsigned DefaultMaxRetry       = 3;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lvds_bit_sync.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, flops clear to 0
//   din   : asynchronous input
//   dout  : synchronized output, two clk edges of latency
module lvds_bit_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/lvds_pll_lock_ctrl.sv
// Lock supervisor and reset sequencer for the LVDS transmit PLL.
// Holds the PLL in reset, waits for lock, requires lock to be stable before
// releasing the serializer reset, and re-resets the PLL on lock loss or timeout.
//   clk       : PLL reference clock
//   rst_n     : asynchronous active-low reset
//   pll_lock  : PLL lock indicator, asynchronous to clk
//   restart   : one-cycle pulse, forces a fresh reset attempt
//   pll_reset : active-high PLL reset
//   tx_rst_n  : active-low serializer reset, high only in RUN
//   locked    : high only in RUN
//   fault     : high only in FAULT
//   retry_cnt : lock timeouts in the current acquisition
//   loss_cnt  : lock losses seen in RUN, saturating at 255
module lvds_pll_lock_ctrl
    import lvds_tx_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYC     = DefaultRstHoldCyc,
    parameter int unsigned LOCK_TIMEOUT_CYC = DefaultLockTimeoutCyc,
    parameter int unsigned LOCK_STABLE_CYC  = DefaultLockStableCyc,
    parameter int unsigned MAX_RETRY        = DefaultMaxRetry
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           pll_lock,
    input  logic                           restart,
    output logic                           pll_reset,
    output logic                           tx_rst_n,
    output logic                           locked,
    output logic                           fault,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
    output logic [7:0]                     loss_cnt
);

    localparam int unsigned CntMax = max3(RST_HOLD_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);

    localparam logic [CntW-1:0]   HoldLast    = CntW'(RST_HOLD_CYC - 1);
    localparam logic [CntW-1:0]   TimeoutLast = CntW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CntW-1:0]   StableLast  = CntW'(LOCK_STABLE_CYC - 1);
    localparam logic [RetryW-1:0] RetryLimit  = RetryW'(MAX_RETRY);

    lock_state_e       state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [RetryW-1:0] retry_q, retry_d, retry_inc;
    logic [7:0]        loss_q, loss_d;
    logic              pll_reset_q, pll_reset_d;
    logic              tx_rst_n_q, tx_rst_n_d;
    logic              locked_q, locked_d;
    logic              fault_q, fault_d;

    logic lock_s;
    logic timeout;
    logic lock_lost;

    lvds_bit_sync u_lock_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (pll_lock),
        .dout (lock_s)
    );

    assign retry_inc = retry_q + RetryW'(1);
    assign timeout   = (state_q == StWait) && !lock_s && (cnt_q == TimeoutLast);
    assign lock_lost = (state_q == StRun) && !lock_s;

    // State register plus counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRst;
            cnt_q   <= '0;
            retry_q <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
        end
    end

    // Next-state logic; restart overrides everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StRst: begin
                if (cnt_q == HoldLast) state_d = StWait;
            end
            StWait: begin
                if (lock_s) begin
                    state_d = StStable;
                end else if (timeout) begin
                    state_d = (retry_inc == RetryLimit) ? StFault : StRst;
                end
            end
            StStable: begin
                if (!lock_s) begin
                    state_d = StWait;
                end else if (cnt_q == StableLast) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!lock_s) state_d = StRst;
            end
            StFault: begin
                state_d = StFault;
            end
            default: state_d = StRst;
        endcase
        if (restart) state_d = StRst;
    end

    // Counter next-state. A restart while already in RST still restarts the hold.
    always_comb begin
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        if (restart || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (state_q inside {StRst, StWait, StStable}) begin
            cnt_d = cnt_q + CntW'(1);
        end

        if (restart) begin
            retry_d = '0;
        end else if (timeout) begin
            retry_d = retry_inc;
        end else if ((state_q == StStable) && (state_d == StRun)) begin
            retry_d = '0;
        end

        if (lock_lost && !restart && (loss_q != 8'hFF)) begin
            loss_d = loss_q + 8'd1;
        end
    end

    // Output decode from next state so outputs move on the same edge as the state.
    always_comb begin
        pll_reset_d = 1'b0;
        tx_rst_n_d  = 1'b0;
        locked_d    = 1'b0;
        fault_d     = 1'b0;
        unique case (state_d)
            StRst: pll_reset_d = 1'b1;
            StWait, StStable: begin
            end
            StRun: begin
                tx_rst_n_d = 1'b1;
                locked_d   = 1'b1;
            end
            StFault: begin
                pll_reset_d = 1'b1;
                fault_d     = 1'b1;
            end
            default: pll_reset_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_reset_q <= 1'b1;
            tx_rst_n_q  <= 1'b0;
            locked_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            pll_reset_q <= pll_reset_d;
            tx_rst_n_q  <= tx_rst_n_d;
            locked_q    <= locked_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_reset = pll_reset_q;
    assign tx_rst_n  = tx_rst_n_q;
    assign locked    = locked_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;

endmodule
